// File: rtl/fft_frame_writer.sv
// fft_frame_writer
// Writer side of the two-bank (ping-pong) FFT display memory. One FFT frame
// arrives as a valid/ready stream of complex bins in FFT output order. Each
// bin is written to the back bank at the address equal to its index in the
// frame. The banks swap only at the start of vertical sync, so the grapher
// reading the front bank never shows a half-written frame.
module fft_frame_writer #(
    parameter int N_POINTS      = 512,  // samples per frame, equals bank depth
    parameter int ADDR_W        = 9,    // log2(N_POINTS)
    parameter int DATA_W        = 16,   // width of the re and im fields
    parameter bit VS_ACTIVE_LOW = 1'b1  // 1: i_vs asserts low
) (
    input  logic              i_clk_24MHz,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_vs,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_re,
    input  logic [DATA_W-1:0] i_im,
    input  logic              i_last,
    output logic              o_wr_en,
    output logic              o_wr_bank,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data0,
    output logic [DATA_W-1:0] o_wr_data1,
    output logic              o_rd_bank,
    output logic              o_frame_err,
    output logic [7:0]        o_frame_cnt
);

    typedef enum logic {
        ST_WRITE     = 1'b0,  // accepting samples into the back bank
        ST_WAIT_SWAP = 1'b1   // frame complete, waiting for vsync to swap
    } state_e;

    // Address of the final sample of a full frame.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic                back_bank_q, back_bank_d;
    logic [ADDR_W-1:0]   cnt_q,       cnt_d;
    logic                vs_prev_q,   vs_prev_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;

    // Registered write port and error pulse.
    logic                wr_en_q,     wr_en_d;
    logic                wr_bank_q,   wr_bank_d;
    logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0]   wr_data0_q,  wr_data0_d;
    logic [DATA_W-1:0]   wr_data1_q,  wr_data1_d;
    logic                frame_err_q, frame_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic vs_act;     // i_vs normalised so that 1 means "sync asserted"
    logic vs_start;   // first cycle of an asserted vsync
    logic accept;     // sample handshake completes this cycle
    logic at_last;    // counter is on the final address of the bank

    assign vs_act   = VS_ACTIVE_LOW ? ~i_vs : i_vs;
    assign vs_start = vs_act & ~vs_prev_q;
    assign at_last  = (cnt_q == LAST_IDX);

    // Ready depends only on state and enable, never on i_valid, and is
    // held low while reset is asserted.
    assign o_ready = i_en & i_rst_n & (state_q == ST_WRITE);
    assign accept  = i_valid & o_ready;

    // ------------------------------------------------------------------
    // Next-state logic: frame length rules, bank swap and write port
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        back_bank_d = back_bank_q;
        cnt_d       = cnt_q;
        vs_prev_d   = vs_prev_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = wr_en_q;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        wr_data0_d  = wr_data0_q;
        wr_data1_d  = wr_data1_q;
        frame_err_d = frame_err_q;

        // With i_en low everything holds, including a write strobe that is
        // still pending; it is released to the RAM on the next enabled cycle.
        if (i_en) begin
            wr_en_d     = 1'b0;
            frame_err_d = 1'b0;
            vs_prev_d   = vs_act;

            unique case (state_q)
                ST_WRITE: begin
                    // vs_start is ignored here; the front bank keeps displaying.
                    if (accept) begin
                        wr_en_d    = 1'b1;
                        wr_bank_d  = back_bank_q;
                        wr_addr_d  = cnt_q;
                        wr_data0_d = i_re;
                        wr_data1_d = i_im;

                        if (i_last && at_last) begin
                            // Good frame.
                            cnt_d   = '0;
                            state_d = ST_WAIT_SWAP;
                        end else if (i_last) begin
                            // Short frame: restart in the same bank, the
                            // partial data is overwritten by the next frame.
                            frame_err_d = 1'b1;
                            cnt_d       = '0;
                        end else if (at_last) begin
                            // Long frame: the bank is full, treat it as done
                            // and let upstream drop the rest.
                            frame_err_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = ST_WAIT_SWAP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                ST_WAIT_SWAP: begin
                    if (vs_start) begin
                        back_bank_d = ~back_bank_q;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = ST_WRITE;
                    end
                end

                default: state_d = ST_WRITE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers with asynchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_24MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_WRITE;
            back_bank_q <= 1'b0;
            cnt_q       <= '0;
            vs_prev_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data0_q  <= '0;
            wr_data1_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values computed for this cycle, independent of order.
            state_q     <= state_d;
            back_bank_q <= back_bank_d;
            cnt_q       <= cnt_d;
            vs_prev_q   <= vs_prev_d;
            frame_cnt_q <= frame_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            wr_data0_q  <= wr_data0_d;
            wr_data1_q  <= wr_data1_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Strobes are masked while disabled; the data fields are plain registers.
    assign o_wr_en     = i_en & wr_en_q;
    assign o_frame_err = i_en & frame_err_q;
    assign o_wr_bank   = wr_bank_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data0  = wr_data0_q;
    assign o_wr_data1  = wr_data1_q;
    assign o_rd_bank   = ~back_bank_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
